// File: rtl/fsm_run_pkg.sv
// Shared definitions for the phase FSM and its run controller.
package fsm_run_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } run_state_t;

  localparam logic [1:0] PH_FIRST   = 2'b11;
  localparam logic [1:0] PH_SECOND  = 2'b01;
  localparam logic [1:0] PH_THIRD   = 2'b10;
  localparam logic [1:0] PH_ILLEGAL = 2'b00;

endpackage

// File: rtl/fsm_run_ctrl.sv
// Sequences N complete FIRST->SECOND->THIRD phase cycles per start request.
//   state | meaning
//   IDLE  | phase FSM parked in FIRST, waiting for start
//   ARM   | restart held until phase FSM reports FIRST
//   RUN   | phase FSM free-running (pause = hold), terminals counted
//   DONE  | one-cycle completion, done pulse visible
//   FAULT | illegal phase encoding seen, sticky until abort
module fsm_run_ctrl
  import fsm_run_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] num_cycles,
  input  logic          hold,
  input  logic [1:0]    fsm_state,
  input  logic          fsm_terminal,
  output logic          fsm_pause,
  output logic          fsm_restart,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          fault,
  output logic [CW-1:0] cycles_done
);

  run_state_t    state, next_state;
  logic [CW-1:0] target;
  logic [CW-1:0] count_next;
  logic          latch, count_en, done_set, abort_set;

  assign count_next = cycles_done + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      target      <= '0;
      cycles_done <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state   <= next_state;
      done    <= done_set;
      aborted <= abort_set;
      if (latch) begin
        target      <= num_cycles;
        cycles_done <= '0;
      end else if (count_en) begin
        cycles_done <= count_next;
      end
    end
  end

  always_comb begin
    next_state  = state;
    fsm_restart = 1'b1;
    fsm_pause   = 1'b1;
    busy        = 1'b0;
    fault       = 1'b0;
    latch       = 1'b0;
    count_en    = 1'b0;
    done_set    = 1'b0;
    abort_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          latch = 1'b1;
          if (num_cycles == '0) begin
            next_state = DONE;
            done_set   = 1'b1;
          end else begin
            next_state = ARM;
          end
        end
      end
      ARM: begin
        busy = 1'b1;
        if (abort) begin
          next_state = IDLE;
          abort_set  = 1'b1;
        end else if (fsm_state == PH_ILLEGAL) begin
          next_state = FAULT;
        end else if (fsm_state == PH_FIRST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        fsm_restart = 1'b0;
        fsm_pause   = hold;
        // abort wins over a coincident terminal, which is then not counted
        if (abort) begin
          next_state = IDLE;
          abort_set  = 1'b1;
        end else if (fsm_state == PH_ILLEGAL) begin
          next_state = FAULT;
        end else if (fsm_terminal) begin
          count_en = 1'b1;
          if (count_next == target) begin
            next_state = DONE;
            done_set   = 1'b1;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      FAULT: begin
        fault = 1'b1;
        if (abort) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_run_ctrl.sv
// Randomized bench for fsm_run_ctrl with a behavioural phase-FSM model and run timeline model.
module tb_fsm_run_ctrl;

  localparam logic [1:0] F1 = 2'b11;
  localparam logic [1:0] F2 = 2'b01;
  localparam logic [1:0] F3 = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] num_cycles = 8'd0;
  logic [1:0] fsm_state;
  logic       fsm_terminal;
  logic       fsm_pause, fsm_restart, busy, done, aborted, fault;
  logic [7:0] cycles_done;

  logic [1:0] ph = 2'b11;
  logic       force_illegal = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  fsm_run_ctrl #(.CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_cycles(num_cycles),
    .hold(hold), .fsm_state(fsm_state), .fsm_terminal(fsm_terminal),
    .fsm_pause(fsm_pause), .fsm_restart(fsm_restart), .busy(busy), .done(done),
    .aborted(aborted), .fault(fault), .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  // behavioural phase FSM: restart forces FIRST, pause stalls, terminal in THIRD when running
  assign fsm_state    = force_illegal ? 2'b00 : ph;
  assign fsm_terminal = (fsm_state == F3) && !fsm_pause && !fsm_restart;

  always @(posedge clk) begin
    if (fsm_restart) ph <= F1;
    else if (!fsm_pause) ph <= (ph == F1) ? F2 : (ph == F2) ? F3 : F1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (aborted !== 1'b0) $display("FAIL reset_aborted: got %b want 0", aborted); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else n_pass++;
    n_checks++; if ({fsm_restart, fsm_pause} !== 2'b11) $display("FAIL reset_restart_pause: got %b want 11", {fsm_restart, fsm_pause}); else n_pass++;
    n_checks++; if (cycles_done !== 8'd0) $display("FAIL reset_cycles: got %0d want 0", cycles_done); else n_pass++;
  endtask

  task automatic test_idle_ignores;
    start = 1'b1; abort = 1'b1; num_cycles = 8'd3;
    tick;
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || aborted !== 1'b0 || done !== 1'b0)
      $display("FAIL start_with_abort: got busy=%b aborted=%b done=%b want 0 0 0", busy, aborted, done); else n_pass++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_checks++; if (aborted !== 1'b0) $display("FAIL idle_abort: got aborted=%b want 0", aborted); else n_pass++;
  endtask

  // timeline model: a run of n cycles needs 3n un-held RUN edges after one ARM edge
  task automatic run_and_check(input int n, input int hold_pct);
    int adv, es, edges;
    logic [1:0] exp_ph;
    adv = 0; edges = 0;
    num_cycles = n[7:0];
    start = 1'b1; hold = 1'b0;
    tick;
    start = 1'b0;
    num_cycles = 8'($urandom);
    es = (n == 0) ? 3 : 1;
    while (edges < 1000) begin
      edges++;
      case (adv % 3)
        0: exp_ph = F1;
        1: exp_ph = F2;
        default: exp_ph = F3;
      endcase
      if (es != 2) exp_ph = F1;
      n_checks++; if (busy !== (es == 1 || es == 2)) $display("FAIL run_busy n=%0d edge=%0d: got %b want %b", n, edges, busy, (es == 1 || es == 2)); else n_pass++;
      n_checks++; if (done !== (es == 3)) $display("FAIL run_done n=%0d edge=%0d: got %b want %b", n, edges, done, (es == 3)); else n_pass++;
      n_checks++; if (fsm_restart !== (es != 2)) $display("FAIL run_restart n=%0d edge=%0d: got %b want %b", n, edges, fsm_restart, (es != 2)); else n_pass++;
      n_checks++; if (fsm_pause !== (es == 2 ? hold : 1'b1)) $display("FAIL run_pause n=%0d edge=%0d: got %b want %b", n, edges, fsm_pause, (es == 2 ? hold : 1'b1)); else n_pass++;
      n_checks++; if (cycles_done !== 8'(adv / 3)) $display("FAIL run_cycles n=%0d edge=%0d: got %0d want %0d", n, edges, cycles_done, adv / 3); else n_pass++;
      n_checks++; if (fsm_state !== exp_ph) $display("FAIL run_phase n=%0d edge=%0d: got %b want %b", n, edges, fsm_state, exp_ph); else n_pass++;
      if (es == 3) break;
      hold = ($urandom_range(99) < hold_pct);
      num_cycles = 8'($urandom);
      tick;
      if (es == 1) es = 2;
      else begin
        if (!hold) adv++;
        if (adv == 3 * n) es = 3;
      end
    end
    n_checks++; if (es != 3) $display("FAIL run_timeout n=%0d: got no done after %0d edges want done", n, edges); else n_pass++;
    hold = 1'b0;
    tick;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0)
      $display("FAIL run_end n=%0d: got busy=%b done=%b aborted=%b want 0 0 0", n, busy, done, aborted); else n_pass++;
    n_checks++; if (cycles_done !== n[7:0]) $display("FAIL run_end_cycles n=%0d: got %0d want %0d", n, cycles_done, n); else n_pass++;
  endtask

  task automatic test_hold;
    int edges, guard;
    bit bad;
    num_cycles = 8'd2;
    start = 1'b1;
    tick;
    start = 1'b0;
    edges = 1; guard = 0;
    while (fsm_state !== F2 && guard < 20) begin tick; edges++; guard++; end
    n_checks++; if (edges != 3) $display("FAIL hold_reach_second: got edge %0d want 3", edges); else n_pass++;
    hold = 1'b1; bad = 1'b0;
    repeat (4) begin
      tick; edges++;
      if (fsm_state !== F2 || cycles_done !== 8'd0) bad = 1'b1;
    end
    hold = 1'b0;
    n_checks++; if (bad) $display("FAIL hold_stall: got phase/count moving want phase 01 count 0"); else n_pass++;
    guard = 0;
    while (done !== 1'b1 && guard < 50) begin tick; edges++; guard++; end
    n_checks++; if (edges != 12) $display("FAIL hold_latency: got done at edge %0d want 12", edges); else n_pass++;
    n_checks++; if (cycles_done !== 8'd2) $display("FAIL hold_cycles: got %0d want 2", cycles_done); else n_pass++;
    tick;
  endtask

  task automatic test_abort(input int n, input int k);
    int guard;
    bit seen;
    num_cycles = n[7:0];
    start = 1'b1;
    tick;
    start = 1'b0;
    guard = 0;
    while (!(fsm_terminal === 1'b1 && cycles_done == 8'(k - 1)) && guard < 200) begin tick; guard++; end
    n_checks++; if (guard >= 200) $display("FAIL abort_wait n=%0d k=%0d: got no terminal want terminal", n, k); else n_pass++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_checks++; if (aborted !== 1'b1) $display("FAIL abort_pulse: got %b want 1", aborted); else n_pass++;
    n_checks++; if (cycles_done !== 8'(k - 1)) $display("FAIL abort_cycles n=%0d k=%0d: got %0d want %0d", n, k, cycles_done, k - 1); else n_pass++;
    n_checks++; if (busy !== 1'b0 || fsm_restart !== 1'b1 || done !== 1'b0)
      $display("FAIL abort_state: got busy=%b restart=%b done=%b want 0 1 0", busy, fsm_restart, done); else n_pass++;
    seen = 1'b0;
    repeat (6) begin
      tick;
      if (done === 1'b1 || aborted === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen) $display("FAIL abort_after: got extra done/aborted pulse want none"); else n_pass++;
  endtask

  task automatic test_fault;
    bit bad;
    num_cycles = 8'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    n_checks++; if (cycles_done !== 8'd1) $display("FAIL fault_pre_cycles: got %0d want 1", cycles_done); else n_pass++;
    force_illegal = 1'b1;
    tick;
    n_checks++; if (fault !== 1'b1 || busy !== 1'b0) $display("FAIL fault_enter: got fault=%b busy=%b want 1 0", fault, busy); else n_pass++;
    n_checks++; if (cycles_done !== 8'd1) $display("FAIL fault_frozen: got %0d want 1", cycles_done); else n_pass++;
    n_checks++; if ({fsm_restart, fsm_pause} !== 2'b11) $display("FAIL fault_outputs: got %b want 11", {fsm_restart, fsm_pause}); else n_pass++;
    force_illegal = 1'b0;
    num_cycles = 8'd3;
    start = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      tick;
      start = 1'b0;
      if (fault !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL fault_sticky: got fault dropped or busy want fault held"); else n_pass++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_checks++; if (fault !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0)
      $display("FAIL fault_clear: got fault=%b aborted=%b busy=%b want 0 0 0", fault, aborted, busy); else n_pass++;
    force_illegal = 1'b1;
    num_cycles = 8'd2;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    n_checks++; if (fault !== 1'b1) $display("FAIL fault_in_arm: got %b want 1", fault); else n_pass++;
    force_illegal = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_checks++; if (fault !== 1'b0 || aborted !== 1'b0) $display("FAIL fault_arm_clear: got fault=%b aborted=%b want 0 0", fault, aborted); else n_pass++;
  endtask

  task automatic test_rst_mid;
    int guard;
    num_cycles = 8'd6;
    start = 1'b1;
    tick;
    start = 1'b0;
    guard = 0;
    while (cycles_done !== 8'd2 && guard < 100) begin tick; guard++; end
    n_checks++; if (guard >= 100) $display("FAIL rst_mid_wait: got cycles %0d want 2", cycles_done); else n_pass++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || cycles_done !== 8'd0) $display("FAIL rst_mid_state: got busy=%b cycles=%0d want 0 0", busy, cycles_done); else n_pass++;
    n_checks++; if ({fsm_restart, fsm_pause} !== 2'b11) $display("FAIL rst_mid_outputs: got %b want 11", {fsm_restart, fsm_pause}); else n_pass++;
    n_checks++; if (done !== 1'b0 || aborted !== 1'b0) $display("FAIL rst_mid_pulse: got done=%b aborted=%b want 0 0", done, aborted); else n_pass++;
    tick;
    n_checks++; if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid_after: got done=%b aborted=%b busy=%b want 0 0 0", done, aborted, busy); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_idle_ignores;
    run_and_check(3, 0);
    test_hold;
    for (int i = 0; i < 6; i++) run_and_check($urandom_range(1, 8), 30);
    run_and_check(0, 0);
    test_abort(5, 2);
    for (int i = 0; i < 3; i++) begin
      int n;
      n = $urandom_range(2, 7);
      test_abort(n, $urandom_range(1, n - 1));
    end
    test_fault;
    test_rst_mid;
    run_and_check(1, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
